systolic_array: RTL and testbench

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

---
 rtl/systolic_array.sv | 100 ++++++++++
 tb/tb_systolic_array.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array.sv
// ============================================================================
// Module   : systolic_array
// Brief    : N x N weight-stationary systolic MAC array with per-node taps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_array #(
    parameter int ARRAY_SIZE = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   load,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]                       weights,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]                       activations,
    output logic [ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH-1:0]            output_row,
    output logic [ARRAY_SIZE*(ARRAY_SIZE+1)*DATA_WIDTH-1:0]        act_tb,
    output logic [ARRAY_SIZE*(ARRAY_SIZE+1)*DATA_WIDTH-1:0]        weight_tb,
    output logic [ARRAY_SIZE*(ARRAY_SIZE+1)*DATA_WIDTH*DATA_WIDTH-1:0] sum_tb
);

    localparam int c_pw    = DATA_WIDTH * DATA_WIDTH;
    localparam int c_nodes = ARRAY_SIZE + 1;

    logic [DATA_WIDTH-1:0] r_weight [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_WIDTH-1:0] r_act    [ARRAY_SIZE][ARRAY_SIZE];
    logic [c_pw-1:0]       r_psum   [ARRAY_SIZE][ARRAY_SIZE];

    logic [DATA_WIDTH-1:0] w_act_in  [ARRAY_SIZE][ARRAY_SIZE];
    logic [c_pw-1:0]       w_psum_in [ARRAY_SIZE][ARRAY_SIZE];
    logic [c_pw-1:0]       w_mac     [ARRAY_SIZE][ARRAY_SIZE];

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
            if (c == 0) begin : g_act_edge
                assign w_act_in[r][c] = activations[r*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_act_chain
                assign w_act_in[r][c] = r_act[r][c-1];
            end

            if (r == 0) begin : g_sum_edge
                assign w_psum_in[r][c] = '0;
            end else begin : g_sum_chain
                assign w_psum_in[r][c] = r_psum[r-1][c];
            end

            // Product is formed at psum width so the accumulate wraps modulo 2^(W*W).
            assign w_mac[r][c] = w_psum_in[r][c]
                               + c_pw'(w_act_in[r][c]) * c_pw'(r_weight[r][c]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ARRAY_SIZE; r++) begin
                for (int c = 0; c < ARRAY_SIZE; c++) begin
                    r_weight[r][c] <= '0;
                    r_act[r][c]    <= '0;
                    r_psum[r][c]   <= '0;
                end
            end
        end else begin
            if (load) begin
                for (int c = 0; c < ARRAY_SIZE; c++) begin
                    r_weight[0][c] <= weights[c*DATA_WIDTH +: DATA_WIDTH];
                    for (int r = 1; r < ARRAY_SIZE; r++) begin
                        r_weight[r][c] <= r_weight[r-1][c];
                    end
                end
            end
            for (int r = 0; r < ARRAY_SIZE; r++) begin
                for (int c = 0; c < ARRAY_SIZE; c++) begin
                    r_act[r][c]  <= w_act_in[r][c];
                    r_psum[r][c] <= w_mac[r][c];
                end
            end
        end
    end

    // Observation taps: node 0 of each chain is the array-edge input.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_tap
        assign output_row[i*c_pw +: c_pw] = r_psum[ARRAY_SIZE-1][i];

        assign act_tb[(i*c_nodes)*DATA_WIDTH +: DATA_WIDTH] =
            activations[i*DATA_WIDTH +: DATA_WIDTH];
        assign weight_tb[(i*c_nodes)*DATA_WIDTH +: DATA_WIDTH] =
            weights[i*DATA_WIDTH +: DATA_WIDTH];
        assign sum_tb[(i*c_nodes)*c_pw +: c_pw] = '0;

        for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_node
            assign act_tb[(i*c_nodes+k+1)*DATA_WIDTH +: DATA_WIDTH]    = r_act[i][k];
            assign weight_tb[(i*c_nodes+k+1)*DATA_WIDTH +: DATA_WIDTH] = r_weight[k][i];
            assign sum_tb[(i*c_nodes+k+1)*c_pw +: c_pw]                = r_psum[k][i];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_array.sv
// ============================================================================
// Module   : tb_systolic_array
// Brief    : Self-checking bench for systolic_array (N=2, W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_array;

    localparam int N  = 2;
    localparam int W  = 4;
    localparam int PW = W * W;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     load = 1'b0;
    logic [N*W-1:0]           weights = '0;
    logic [N*W-1:0]           activations = '0;
    logic [N*PW-1:0]          output_row;
    logic [N*(N+1)*W-1:0]     act_tb;
    logic [N*(N+1)*W-1:0]     weight_tb;
    logic [N*(N+1)*PW-1:0]    sum_tb;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int due;
        int col;
        int val;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  vecs[$];
    int          wexp[N][N];

    systolic_array #(.ARRAY_SIZE(N), .DATA_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .weights     (weights),
        .activations (activations),
        .output_row  (output_row),
        .act_tb      (act_tb),
        .weight_tb   (weight_tb),
        .sum_tb      (sum_tb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] wtap(int r, int c);
        return weight_tb[(c*(N+1)+r+1)*W +: W];
    endfunction

    function automatic logic [W-1:0] atap(int r, int k);
        return act_tb[(r*(N+1)+k)*W +: W];
    endfunction

    function automatic logic [PW-1:0] stap(int r, int c);
        return sum_tb[(c*(N+1)+r+1)*PW +: PW];
    endfunction

    function automatic logic [PW-1:0] orow(int c);
        return output_row[c*PW +: PW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First-loaded vector ends in row N-1, so feed rows bottom-up.
    task automatic load_weights();
        load = 1'b1;
        for (int k = 0; k < N; k++) begin
            for (int c = 0; c < N; c++)
                weights[c*W +: W] = W'(wexp[N-1-k][c]);
            tick();
        end
        load = 1'b0;
        weights = '0;
    endtask

    // Drives vecs with row skew; expected column sums are queued on issue.
    task automatic run_stream(input string name);
        int nvec;
        int last;
        logic [7:0] v;
        nvec = vecs.size();
        last = nvec + 2 * N;
        for (int t = 0; t <= last; t++) begin
            for (int r = 0; r < N; r++) begin
                if (t - r >= 0 && t - r < nvec) begin
                    v = vecs[t-r];
                    activations[r*W +: W] = v[r*W +: W];
                end else begin
                    activations[r*W +: W] = '0;
                end
            end
            if (t < nvec) begin
                v = vecs[t];
                for (int c = 0; c < N; c++) begin
                    exp_t e;
                    e.due = t + c + N - 1;
                    e.col = c;
                    e.val = 0;
                    for (int r = 0; r < N; r++)
                        e.val += int'(v[r*W +: W]) * wexp[r][c];
                    e.val = e.val % 65536;
                    sb.push_back(e);
                end
            end
            tick();
            while (sb.size() > 0 && sb[0].due == t) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (orow(e.col) !== PW'(e.val)) begin
                    errors++;
                    $display("FAIL %s col%0d edge%0d: got %0d expected %0d",
                             name, e.col, t, orow(e.col), e.val);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s scoreboard: %0d results never produced, expected 0", name, sb.size());
            sb.delete();
        end
        activations = '0;
        vecs.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load = 1'b1;
        weights = 8'hFF;
        activations = 8'hFF;
        repeat (3) tick();
        checks++;
        if (output_row !== '0) begin
            errors++;
            $display("FAIL reset output_row: got %h expected 0", output_row);
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                checks++;
                if (wtap(r, c) !== '0 || stap(r, c) !== '0 || atap(r, c+1) !== '0) begin
                    errors++;
                    $display("FAIL reset taps r%0d c%0d: got w=%0d s=%0d a=%0d expected 0",
                             r, c, wtap(r, c), stap(r, c), atap(r, c+1));
                end
            end
            checks++;
            if (atap(r, 0) !== 4'hF) begin
                errors++;
                $display("FAIL reset act node0 row%0d: got %0d expected 15", r, atap(r, 0));
            end
        end
        load = 1'b0;
        weights = '0;
        activations = '0;
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        wexp = '{'{1, 2}, '{3, 4}};
        load_weights();
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    checks++;
                    if (wtap(r, c) !== W'(wexp[r][c])) begin
                        errors++;
                        $display("FAIL load pass%0d w[%0d][%0d]: got %0d expected %0d",
                                 pass, r, c, wtap(r, c), wexp[r][c]);
                    end
                end
            end
            if (pass == 0) begin
                for (int k = 0; k < 5; k++) begin
                    weights = 8'($urandom);
                    tick();
                end
                weights = '0;
            end
        end
    endtask

    task automatic test_compute();
        activations = 8'h01;
        tick();
        checks++;
        if (stap(0, 0) !== 16'd1 || atap(0, 1) !== 4'd1) begin
            errors++;
            $display("FAIL compute E0: got psum00=%0d act01=%0d expected 1 1", stap(0, 0), atap(0, 1));
        end
        activations = 8'h23;
        tick();
        checks++;
        if (orow(0) !== 16'd7 || atap(0, 2) !== 4'd1) begin
            errors++;
            $display("FAIL compute E1: got c0=%0d act02=%0d expected 7 1", orow(0), atap(0, 2));
        end
        activations = 8'h40;
        tick();
        checks++;
        if (orow(0) !== 16'd15 || orow(1) !== 16'd10) begin
            errors++;
            $display("FAIL compute E2: got c0=%0d c1=%0d expected 15 10", orow(0), orow(1));
        end
        activations = 8'h00;
        tick();
        checks++;
        if (orow(1) !== 16'd22 || orow(0) !== 16'd0) begin
            errors++;
            $display("FAIL compute E3: got c1=%0d c0=%0d expected 22 0", orow(1), orow(0));
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wexp[r][c] = int'($urandom_range(0, 15));
        load_weights();
        for (int i = 0; i < 8; i++)
            vecs.push_back(8'($urandom));
        run_stream("b2b");
    endtask

    task automatic test_wrap();
        wexp = '{'{15, 15}, '{15, 15}};
        load_weights();
        repeat (3) vecs.push_back(8'hFF);
        run_stream("maxval");
    endtask

    task automatic test_midrun_reset();
        wexp = '{'{1, 2}, '{3, 4}};
        load_weights();
        activations = 8'h01;
        tick();
        activations = 8'h23;
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (output_row !== '0) begin
            errors++;
            $display("FAIL midreset output_row: got %h expected 0", output_row);
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                checks++;
                if (wtap(r, c) !== '0) begin
                    errors++;
                    $display("FAIL midreset w[%0d][%0d]: got %0d expected 0", r, c, wtap(r, c));
                end
            end
        end
        activations = '0;
        #1 reset = 1'b1;
        wexp = '{'{0, 0}, '{0, 0}};
        vecs.push_back(8'h23);
        vecs.push_back(8'hF7);
        run_stream("postreset");
    endtask

    initial begin
        test_reset();
        test_load();
        test_compute();
        test_back_to_back();
        test_wrap();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
